// File: rtl/led_pwm_ctrl_if.sv
// Peripheral bus bundle between the CPU-side requester and the LED/PWM controller.
// One request per valid/ready handshake; ready is a single-cycle completion pulse.
interface led_pwm_ctrl_if;
    logic        valid;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid,
        output we,
        output addr,
        output wdata,
        input  ready,
        input  rdata
    );

    modport slave (
        input  valid,
        input  we,
        input  addr,
        input  wdata,
        output ready,
        output rdata
    );
endinterface

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped LED controller: four plain LEDs with optional blink and two RGB LEDs
// driven by a shared prescaler + 8-bit PWM timebase with period-aligned duty updates.
module led_pwm_ctrl #(
    parameter int                    PRESCALE_W     = 16,
    parameter logic [PRESCALE_W-1:0] RESET_PRESCALE = PRESCALE_W'(487)
) (
    input  logic                 clk,
    input  logic                 rst,
    led_pwm_ctrl_if.slave        bus,
    output logic [3:0]           leds,
    output logic [2:0]           rgb_led_ld4,
    output logic [2:0]           rgb_led_ld5
);

    typedef enum logic {
        IDLE,
        RESP
    } bus_state_t;

    localparam logic [3:0] ADDR_CTRL     = 4'd0;
    localparam logic [3:0] ADDR_LEDS     = 4'd1;
    localparam logic [3:0] ADDR_LD4      = 4'd2;
    localparam logic [3:0] ADDR_LD5      = 4'd3;
    localparam logic [3:0] ADDR_PRESCALE = 4'd4;
    localparam logic [3:0] ADDR_STATUS   = 4'd5;

    bus_state_t            state_q;
    bus_state_t            state_d;
    logic                  accept;
    logic                  ready;
    logic                  wr_en;
    logic                  rd_en;
    logic [31:0]           rd_val;
    logic [31:0]           rdata_q;

    logic                  pwm_en;
    logic                  blink_en;
    logic [3:0]            leds_reg;
    logic [PRESCALE_W-1:0] prescale;
    logic [23:0]           shadow_ld4;
    logic [23:0]           shadow_ld5;
    logic [23:0]           active_ld4;
    logic [23:0]           active_ld5;

    logic [PRESCALE_W-1:0] pre_cnt;
    logic [7:0]            pwm_cnt;
    logic                  period_done;
    logic                  tick;
    logic                  wrap;

    logic [3:0]            leds_q;
    logic [2:0]            rgb4_q;
    logic [2:0]            rgb5_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A request is only taken in IDLE, so valid still high during RESP is not re-accepted.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    accept  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_en = accept & bus.we;
    assign rd_en = accept & ~bus.we;

    always_comb begin
        rd_val = '0;
        case (bus.addr)
            ADDR_CTRL:     rd_val[1:0]            = {blink_en, pwm_en};
            ADDR_LEDS:     rd_val[3:0]            = leds_reg;
            ADDR_LD4:      rd_val[23:0]           = shadow_ld4;
            ADDR_LD5:      rd_val[23:0]           = shadow_ld5;
            ADDR_PRESCALE: rd_val[PRESCALE_W-1:0] = prescale;
            ADDR_STATUS:   rd_val[8:0]            = {period_done, pwm_cnt};
            default:       rd_val                 = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_en     <= 1'b0;
            blink_en   <= 1'b0;
            leds_reg   <= '0;
            prescale   <= RESET_PRESCALE;
            shadow_ld4 <= '0;
            shadow_ld5 <= '0;
            rdata_q    <= '0;
        end else begin
            if (wr_en) begin
                case (bus.addr)
                    ADDR_CTRL: begin
                        pwm_en   <= bus.wdata[0];
                        blink_en <= bus.wdata[1];
                    end
                    ADDR_LEDS:     leds_reg   <= bus.wdata[3:0];
                    ADDR_LD4:      shadow_ld4 <= bus.wdata[23:0];
                    ADDR_LD5:      shadow_ld5 <= bus.wdata[23:0];
                    ADDR_PRESCALE: prescale   <= bus.wdata[PRESCALE_W-1:0];
                    default: ;
                endcase
            end
            if (rd_en) begin
                rdata_q <= rd_val;
            end
        end
    end

    assign tick = pwm_en && (pre_cnt == prescale);
    assign wrap = tick && (pwm_cnt == 8'hFF);

    // The pre_cnt > prescale case restarts the count after a smaller reload is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt    <= '0;
            pwm_cnt    <= '0;
            active_ld4 <= '0;
            active_ld5 <= '0;
        end else if (!pwm_en) begin
            pre_cnt    <= '0;
            pwm_cnt    <= '0;
            active_ld4 <= shadow_ld4;
            active_ld5 <= shadow_ld5;
        end else begin
            if (tick || (pre_cnt > prescale)) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
            if (wrap) begin
                active_ld4 <= shadow_ld4;
                active_ld5 <= shadow_ld5;
            end
        end
    end

    // Setting has priority so a wrap coinciding with a STATUS read is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_done <= 1'b0;
        end else if (wrap) begin
            period_done <= 1'b1;
        end else if (rd_en && (bus.addr == ADDR_STATUS)) begin
            period_done <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb4_q <= '0;
            rgb5_q <= '0;
            leds_q <= '0;
        end else begin
            if (pwm_en) begin
                rgb4_q <= {pwm_cnt < active_ld4[23:16], pwm_cnt < active_ld4[15:8], pwm_cnt < active_ld4[7:0]};
                rgb5_q <= {pwm_cnt < active_ld5[23:16], pwm_cnt < active_ld5[15:8], pwm_cnt < active_ld5[7:0]};
            end else begin
                rgb4_q <= '0;
                rgb5_q <= '0;
            end
            leds_q <= blink_en ? (leds_reg & {4{pwm_cnt[7]}}) : leds_reg;
        end
    end

    assign bus.ready   = ready;
    assign bus.rdata   = rdata_q;
    assign leds        = leds_q;
    assign rgb_led_ld4 = rgb4_q;
    assign rgb_led_ld5 = rgb5_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed self-checking bench for led_pwm_ctrl: bus timing, PWM duty, period-aligned
// duty updates, blink, disable and prescale behaviour, with hand-derived expectations.
module tb_led_pwm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] leds;
    logic [2:0] ld4;
    logic [2:0] ld5;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    led_pwm_ctrl_if bus ();

    led_pwm_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .leds        (leds),
        .rgb_led_ld4 (ld4),
        .rgb_led_ld5 (ld5)
    );

    task automatic bus_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int lat);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.we    = we;
        bus.addr  = addr;
        bus.wdata = wdata;
        lat       = 0;
        rdata     = '0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready === 1'b1) begin
                lat   = i;
                rdata = bus.rdata;
                break;
            end
        end
        @(negedge clk);
        bus.valid = 1'b0;
        bus.we    = 1'b0;
        if (lat == 0) begin
            $display("[TB] FAIL bus_timeout: addr %0d got no ready, required ready within 8 cycles", addr);
            checks++;
        end
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        int          l;
        bus_xfer(1'b1, addr, wdata, d, l);
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] rdata);
        int l;
        bus_xfer(1'b0, addr, 32'h0, rdata, l);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bit          ready_seen;
        rst       = 1'b1;
        bus.valid = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus_write(4'd1, 32'h5);
        @(negedge clk);
        bus.valid  = 1'b1;
        bus.we     = 1'b0;
        bus.addr   = 4'd1;
        #2 rst     = 1'b1;
        ready_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready !== 1'b0) ready_seen = 1'b1;
        end
        @(negedge clk);
        bus.valid = 1'b0;
        rst       = 1'b0;
        checks++;
        if (ready_seen) $display("[TB] FAIL reset_abort: ready pulsed during reset, required no pulse");
        else passes++;
        checks++;
        if (leds !== 4'h0) $display("[TB] FAIL reset_leds: got %h, required 0", leds);
        else passes++;
        checks++;
        if ({ld4, ld5} !== 6'h0) $display("[TB] FAIL reset_rgb: got %b_%b, required 0", ld4, ld5);
        else passes++;
        checks++;
        if (bus.rdata !== 32'h0) $display("[TB] FAIL reset_rdata: got %h, required 0", bus.rdata);
        else passes++;
        bus_read(4'd4, d);
        checks++;
        if (d !== 32'h0000_01E7) $display("[TB] FAIL reset_prescale: got %h, required 000001e7", d);
        else passes++;
        bus_read(4'd1, d);
        checks++;
        if (d !== 32'h0) $display("[TB] FAIL reset_leds_reg: got %h, required 0", d);
        else passes++;
    endtask

    task automatic test_bus_timing();
        logic [31:0] d;
        int          lat;
        bus_xfer(1'b1, 4'd1, 32'hA, d, lat);
        checks++;
        if (lat !== 1) $display("[TB] FAIL write_latency: got %0d, required 1", lat);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b0) $display("[TB] FAIL ready_width: got %b one cycle later, required 0", bus.ready);
        else passes++;
        bus_xfer(1'b0, 4'd1, 32'h0, d, lat);
        checks++;
        if (lat !== 1) $display("[TB] FAIL read_latency: got %0d, required 1", lat);
        else passes++;
        checks++;
        if (d !== 32'h0000_000A) $display("[TB] FAIL read_leds: got %h, required 0000000a", d);
        else passes++;
        checks++;
        if (leds !== 4'hA) $display("[TB] FAIL leds_out: got %h, required a", leds);
        else passes++;
        bus_write(4'd7, 32'hFFFF_FFFF);
        bus_read(4'd7, d);
        checks++;
        if (d !== 32'h0) $display("[TB] FAIL unmapped_read: got %h, required 0", d);
        else passes++;
        bus_read(4'd1, d);
        checks++;
        if (d !== 32'h0000_000A) $display("[TB] FAIL unmapped_write_ignored: got %h, required 0000000a", d);
        else passes++;
    endtask

    task automatic test_pwm_duty();
        int r_hi = 0;
        int g_hi = 0;
        int b_hi = 0;
        int l5_hi = 0;
        bus_write(4'd4, 32'h0);
        bus_write(4'd2, 32'h00FF_0040);
        bus_write(4'd0, 32'h1);
        repeat (4) @(posedge clk);
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1;
            if (ld4[0] === 1'b1) r_hi++;
            if (ld4[1] === 1'b1) g_hi++;
            if (ld4[2] === 1'b1) b_hi++;
            if (ld5 !== 3'b000) l5_hi++;
        end
        checks++;
        if (r_hi !== 64) $display("[TB] FAIL duty_r64: got %0d high cycles, required 64", r_hi);
        else passes++;
        checks++;
        if (g_hi !== 0) $display("[TB] FAIL duty_g0: got %0d high cycles, required 0", g_hi);
        else passes++;
        checks++;
        if (b_hi !== 255) $display("[TB] FAIL duty_b255: got %0d high cycles, required 255", b_hi);
        else passes++;
        checks++;
        if (l5_hi !== 0) $display("[TB] FAIL duty_ld5_idle: got %0d active cycles, required 0", l5_hi);
        else passes++;
    endtask

    task automatic test_glitch_free();
        logic [31:0] d;
        bit          found = 1'b0;
        bit          glitch = 1'b0;
        bit          rose = 1'b0;
        bit          fell = 1'b0;
        logic        prev;
        int          r5_hi = 0;
        int          r4_hi = 0;
        bus_write(4'd4, 32'd9);
        for (int i = 0; i < 2000 && !found; i++) begin
            bus_read(4'd5, d);
            if (d[7:0] >= 8'd5 && d[7:0] <= 8'd20) found = 1'b1;
        end
        checks++;
        if (!found) $display("[TB] FAIL sync_cnt10: pwm_cnt window not reached, last %0d", d[7:0]);
        else passes++;
        bus_write(4'd3, 32'h0000_00C8);
        prev = ld4[0];
        for (int i = 0; i < 6000 && !rose; i++) begin
            @(posedge clk);
            #1;
            if (prev === 1'b1 && ld4[0] === 1'b0) fell = 1'b1;
            if (fell && prev === 1'b0 && ld4[0] === 1'b1) rose = 1'b1;
            else if (ld5[0] !== 1'b0) glitch = 1'b1;
            prev = ld4[0];
        end
        checks++;
        if (glitch) $display("[TB] FAIL shadow_hold: ld5 R went high before wrap, required low");
        else passes++;
        checks++;
        if (!rose || ld5[0] !== 1'b1) $display("[TB] FAIL wrap_load: ld5 R at wrap got %b (wrap seen %b), required 1", ld5[0], rose);
        else passes++;
        r5_hi = (ld5[0] === 1'b1) ? 1 : 0;
        r4_hi = (ld4[0] === 1'b1) ? 1 : 0;
        for (int i = 1; i < 2560; i++) begin
            @(posedge clk);
            #1;
            if (ld5[0] === 1'b1) r5_hi++;
            if (ld4[0] === 1'b1) r4_hi++;
        end
        checks++;
        if (r5_hi !== 2000) $display("[TB] FAIL duty_r200: got %0d high cycles, required 2000", r5_hi);
        else passes++;
        checks++;
        if (r4_hi !== 640) $display("[TB] FAIL duty_r64_pre9: got %0d high cycles, required 640", r4_hi);
        else passes++;
        bus_read(4'd5, d);
        checks++;
        if (d[8] !== 1'b1) $display("[TB] FAIL period_done_set: got %b, required 1", d[8]);
        else passes++;
        bus_read(4'd5, d);
        checks++;
        if (d[8] !== 1'b0) $display("[TB] FAIL period_done_clear: got %b, required 0", d[8]);
        else passes++;
    endtask

    task automatic test_blink();
        logic [3:0] prev;
        logic [3:0] first_val = 4'h0;
        bit         changed = 1'b0;
        int         len;
        bus_write(4'd4, 32'h0);
        bus_write(4'd1, 32'hF);
        bus_write(4'd0, 32'h3);
        repeat (4) @(posedge clk);
        #1;
        prev = leds;
        for (int i = 0; i < 300 && !changed; i++) begin
            @(posedge clk);
            #1;
            if (leds !== prev) changed = 1'b1;
        end
        checks++;
        if (!changed) $display("[TB] FAIL blink_toggle: leds stuck at %h, required toggling", leds);
        else passes++;
        for (int run = 0; run < 2; run++) begin
            prev = leds;
            if (run == 0) first_val = leds;
            len  = 1;
            for (int i = 0; i < 300; i++) begin
                @(posedge clk);
                #1;
                if (leds !== prev) break;
                len++;
            end
            checks++;
            if (len !== 128) $display("[TB] FAIL blink_period%0d: got %0d cycles, required 128", run, len);
            else passes++;
            checks++;
            if (prev !== ((run == 0) ? first_val : ~first_val) || (prev !== 4'h0 && prev !== 4'hF))
                $display("[TB] FAIL blink_value%0d: got %h, required 0/f alternating", run, prev);
            else passes++;
        end
    endtask

    task automatic test_disable_prescale();
        logic [31:0] d;
        logic        prev;
        bit          rose = 1'b0;
        int          hi_len = 0;
        int          per = 0;
        bus_write(4'd0, 32'h1);
        bus_write(4'd2, 32'h0000_0001);
        repeat (300) @(posedge clk);
        bus_write(4'd4, 32'd2);
        #1;
        prev = ld4[0];
        for (int i = 0; i < 2000 && !rose; i++) begin
            @(posedge clk);
            #1;
            if (prev === 1'b0 && ld4[0] === 1'b1) rose = 1'b1;
            prev = ld4[0];
        end
        hi_len = 1;
        per    = 1;
        rose   = 1'b0;
        for (int i = 0; i < 2000 && !rose; i++) begin
            @(posedge clk);
            #1;
            if (prev === 1'b0 && ld4[0] === 1'b1) rose = 1'b1;
            else begin
                per++;
                if (ld4[0] === 1'b1) hi_len++;
            end
            prev = ld4[0];
        end
        checks++;
        if (hi_len !== 3) $display("[TB] FAIL prescale2_tick: got %0d cycles at cnt 0, required 3", hi_len);
        else passes++;
        checks++;
        if (per !== 768) $display("[TB] FAIL prescale2_period: got %0d cycles, required 768", per);
        else passes++;
        repeat (100) @(posedge clk);
        bus_write(4'd0, 32'h0);
        @(posedge clk);
        #1;
        checks++;
        if ({ld4, ld5} !== 6'h0) $display("[TB] FAIL disable_rgb: got %b_%b, required 0", ld4, ld5);
        else passes++;
        bus_read(4'd5, d);
        checks++;
        if (d[7:0] !== 8'h0) $display("[TB] FAIL disable_cnt: got %0d, required 0", d[7:0]);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_bus_timing();
        test_pwm_duty();
        test_glitch_free();
        test_blink();
        test_disable_prescale();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
- Memory-mapped controller that drives the board LEDs of moggysoc_top: 4 plain LEDs (leds) and two RGB LEDs (rgb_led_ld4, rgb_led_ld5).
- Sits on the SoC peripheral bus behind the CPU.
- Owns a shared prescaler and an 8-bit PWM timebase that it applies to six duty-cycle channels.
- Double-buffers duty values so software updates never glitch a PWM period.

Parameters:
- PRESCALE_W, 16, width of the prescaler reload register.
- RESET_PRESCALE, 16'd487, prescaler reload after reset (~1 kHz PWM period at 125 MHz).

Ports:
- clk  input  1  system clock (clk_125 domain).
- rst  input  1  asynchronous, active-high reset.
- bus_valid  input  1  request strobe; held until bus_ready.
- bus_we  input  1  1 = write, 0 = read.
- bus_addr  input  4  word address (byte address [5:2]).
- bus_wdata  input  32  write data.
- bus_ready  output  1  one-cycle completion pulse.
- bus_rdata  output  32  read data, valid while bus_ready=1.
- leds  output  4  plain LED outputs.
- rgb_led_ld4  output  3  {B,G,R} PWM outputs.
- rgb_led_ld5  output  3  {B,G,R} PWM outputs.

Behaviour:
- Register map (word addresses):
  - 0 CTRL: [0] pwm_en, [1] blink_en.
  - 1 LEDS: [3:0] LED value.
  - 2 LD4: [7:0] R, [15:8] G, [23:16] B.
  - 3 LD5: same layout as LD4.
  - 4 PRESCALE: [PRESCALE_W-1:0].
  - 5 STATUS (RO): [7:0] pwm_cnt, [8] period_done sticky flag.
  - Unmapped addresses: reads return 0, writes are ignored.
- Reset values:
  - All outputs 0; bus_ready 0; bus_rdata 0.
  - CTRL = 0; LEDS = 0; duty shadow and active registers = 0.
  - PRESCALE = RESET_PRESCALE; counters = 0; STATUS[8] = 0.
- Bus FSM: IDLE -> RESP -> IDLE.
  - In IDLE with bus_valid=1: capture request, perform write or latch read data, go to RESP.
  - In RESP: bus_ready=1 for exactly one cycle, then IDLE.
  - Latency: ready 1 cycle after valid is sampled.
  - Requester drops or re-asserts valid after ready. valid sampled high in RESP is ignored; it is accepted the following IDLE cycle.
- Writes:
  - CTRL, LEDS and PRESCALE take effect the next cycle.
  - LD4/LD5 writes go to shadow registers only.
- STATUS read returns the current pwm_cnt and clears period_done in the same cycle. If a set event coincides with the clearing read, the set wins.
- Prescaler:
  - When pwm_en=1: pre_cnt counts 0..PRESCALE, and tick pulses when pre_cnt==PRESCALE, then pre_cnt reloads to 0.
  - PRESCALE=0 gives a tick every cycle.
  - A PRESCALE write below the current pre_cnt forces pre_cnt to 0 the next cycle (no long wrap).
- PWM counter:
  - On tick: pwm_cnt increments, wrapping 255 -> 0.
  - On the wrap, all six active duties load from shadow and period_done is set.
- Channel outputs:
  - Channel out = (pwm_cnt < duty_active). Duty 0 means always off; 255 gives 255/256 on.
  - Outputs are registered (1-cycle delay from counter).
- pwm_en=0:
  - pre_cnt and pwm_cnt hold at 0 and RGB outputs are 0.
  - Shadow duties copy into active immediately, so the next enable starts with fresh values.
- Blink:
  - blink_en=1: leds = LEDS & {4{pwm_cnt[7]}}.
  - blink_en=0: leds = LEDS.
- Asynchronous reset mid-transaction aborts the transaction: bus_ready stays 0 and registers return to reset values.

Test Plan:
- Reset:
  - Assert rst mid-read of LEDS -> bus_ready never pulses.
  - All outputs 0; PRESCALE readback = 487 (16'h01E7).
- Bus timing:
  - Write LEDS=4'hA, then read addr 1 -> bus_ready exactly 1 cycle after each valid.
  - rdata = 32'h0000000A; leds = 4'hA; unmapped addr 7 reads 0.
- PWM duty:
  - PRESCALE=0, LD4 R=64, G=0, B=255, CTRL=1.
  - Over one 256-tick period: R high 64 cycles, G never high, B high 255 cycles.
- Glitch-free update:
  - Write LD5 R=200 while pwm_cnt=10 -> output unchanged until pwm_cnt wraps to 0.
  - Next period R high 200 cycles; STATUS[8]=1, and a second read returns 0.
- Blink:
  - CTRL=3, LEDS=4'hF, PRESCALE=0 -> leds toggles between 0 and F every 128 cycles.
- Disable / prescale change:
  - Clear pwm_en mid-period -> RGB outputs 0 next cycle and pwm_cnt reads 0.
  - PRESCALE=2 during count -> tick every 3 cycles.
